// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the iterative decrypt datapath.
// Includes the state type, GF(2^8) helpers and the inverse S-box.
package aes_pkg;
    localparam int NR = 10;
    localparam int NB = 4;

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_e;

    // Byte 0 is the most significant byte, so a plain cast keeps FIPS-197 order.
    typedef logic [0:15][7:0] state_t;

    function automatic state_t to_state(input logic [127:0] d);
        return state_t'(d);
    endfunction

    function automatic logic [127:0] from_state(input state_t s);
        return 128'(s);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] bb;
        p  = '0;
        x  = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ x;
            x  = xtime(x);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // InvMixColumns row 0 coefficients; other rows are rotations of this one.
    function automatic logic [7:0] inv_mc_coef(input int j);
        case (j)
            0:       return 8'h0e;
            1:       return 8'h0b;
            2:       return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        case (b)
            8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
            8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
            8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
            8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
            8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
            8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
            8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
            8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
            8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
            8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
            8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
            8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
            8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
            8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
            8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
            8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
            8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
            8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
            8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
            8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
            8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
            8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
            8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
            8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
            8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
            8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
            8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
            8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
            8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
            8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
            8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
            8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
            default: r = '0;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey
// and, unless this is the final round, InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] res
);
    state_t s;
    state_t k;
    state_t ak;
    state_t mc;

    assign s = to_state(st);
    assign k = to_state(rk);

    // Byte index is 4*column + row; row r rotates right by r columns.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;

        assign ak[gi] = inv_sbox(s[SRC]) ^ k[gi];
        assign mc[gi] = gf_mul(ak[4*COL+0], inv_mc_coef((4 - ROW) % 4))
                      ^ gf_mul(ak[4*COL+1], inv_mc_coef((5 - ROW) % 4))
                      ^ gf_mul(ak[4*COL+2], inv_mc_coef((6 - ROW) % 4))
                      ^ gf_mul(ak[4*COL+3], inv_mc_coef((7 - ROW) % 4));
    end

    assign res = from_state(last ? ak : mc);
endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: initial AddRoundKey on accept, then one
// inverse round per clock with round keys fetched by index.
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);
    localparam logic [3:0] FIRST_KEY = 4'(NR);
    localparam logic [3:0] LAST_CNT  = 4'(NR - 1);

    fsm_e         state_q;
    fsm_e         state_d;
    logic [127:0] st_q;
    logic [127:0] st_d;
    logic [3:0]   cnt_q;
    logic [3:0]   cnt_d;
    logic [127:0] round_out;
    logic         last;

    assign last = (cnt_q == 4'd0);

    aes_inv_round u_round (
        .st   (st_q),
        .rk   (rk),
        .last (last),
        .res  (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        st_d      = st_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = FIRST_KEY;
        unique case (state_q)
            S_IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    st_d    = in_data ^ rk;
                    cnt_d   = LAST_CNT;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                rk_idx = cnt_q;
                st_d   = round_out;
                if (last) state_d = S_DONE;
                else      cnt_d   = cnt_q - 4'd1;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_data = st_q;
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Scoreboarded bench for aes_decrypt_iter against a byte-matrix AES model
// whose tables are derived from GF(2^8) inversion and the affine map.
module tb_aes_decrypt_iter;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    logic [127:0] ks [0:15];
    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] exp_q [$];
    string        nm_q  [$];
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rk = ks[rk_idx];

    aes_decrypt_iter #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int r;
        int x;
        r = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
        end
        return r[7:0];
    endfunction

    task automatic build_tables();
        int inv;
        int a;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = y;
            a = inv;
            for (int k = 1; k < 5; k++) a = a ^ (((inv << k) | (inv >> (8 - k))) & 'hff);
            a = a ^ 'h63;
            sbox[x] = a[7:0];
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) ks[r] = '0;
        for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Textbook decryption on a 4x4 byte matrix m[row][col].
    function automatic logic [127:0] model_dec(input logic [127:0] ct);
        logic [7:0]   m  [4][4];
        logic [7:0]   t  [4][4];
        logic [7:0]   im [4][4];
        logic [127:0] v;
        logic [7:0]   acc;
        im = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
               '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
        v = ct ^ ks[10];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) m[r][c] = v[127 - 8*(4*c+r) -: 8];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r][(c+r)%4] = isbox[m[r][c]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) v[127 - 8*(4*c+r) -: 8] = t[r][c];
            v = v ^ ks[rnd];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) m[r][c] = v[127 - 8*(4*c+r) -: 8];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) acc = acc ^ gmul(im[r][k], m[k][c]);
                        v[127 - 8*(4*c+r) -: 8] = acc;
                    end
            end
        end
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offers a block; the expectation is queued at the negedge before the accepting edge.
    task automatic send(input logic [127:0] ct, input logic [127:0] want, input string nm, output int acc);
        in_data  = ct;
        in_valid = 1'b1;
        acc      = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            total++;
            bad++;
            $display("FAIL %s accept_timeout got=no_accept want=accept", nm);
        end else begin
            exp_q.push_back(want);
            nm_q.push_back(nm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s drain_timeout got=%0d_pending want=0", nm, exp_q.size());
            exp_q.delete();
            nm_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic c1_run(input bit scramble, input string tag);
        int acc;
        int d;
        bit got;
        load_key(KEY_C1);
        send(CT_C1, PT_C1, {tag, "_data"}, acc);
        in_valid = 1'b0;
        got = 1'b0;
        d   = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            d = cyc - acc;
            if (out_valid) got = 1'b1;
            else if (d >= 1 && d <= 10) chk($sformatf("%s_rk_idx_d%0d", tag, d), 128'(rk_idx), 128'(10 - d));
            if (scramble) in_data = rand128();
        end
        chk({tag, "_latency"}, got ? 128'(d) : 128'(0), 128'(11));
        drain(tag);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output got=%h want=none", out_data);
            end else begin
                string        nm;
                logic [127:0] e;
                nm = nm_q.pop_front();
                e  = exp_q.pop_front();
                chk(nm, out_data, e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           acc;
        int           accs [3];
        logic [127:0] ct2;
        logic [127:0] exp2;
        logic [127:0] cts [3];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        build_tables();
        load_key(KEY_C1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_low", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_rk_idx", 128'(rk_idx), 128'(10));
        chk("rst_in_ready_high", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;

        c1_run(1'b0, "c1");

        load_key(KEY_B);
        send(CT_B, PT_B, "appb_data", acc);
        in_valid = 1'b0;
        drain("appb");

        // Backpressure: hold the first result while a second block waits.
        load_key(KEY_C1);
        out_ready = 1'b0;
        send(CT_C1, PT_C1, "bp_blk1", acc);
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        chk("bp_reach_done", 128'(out_valid), 128'(1));
        @(posedge clk);
        #1;
        ct2      = rand128();
        exp2     = model_dec(ct2);
        in_data  = ct2;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_valid_%0d", i), 128'(out_valid), 128'(1));
            chk($sformatf("bp_hold_data_%0d", i), out_data, PT_C1);
            chk($sformatf("bp_hold_in_ready_%0d", i), 128'(in_ready), 128'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_accept_at_handshake", 128'(in_ready), 128'(0));
        @(negedge clk);
        chk("bp_accept_next_cycle", 128'(in_ready), 128'(1));
        if (in_ready) begin
            exp_q.push_back(exp2);
            nm_q.push_back("bp_blk2");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("bp");

        c1_run(1'b1, "stable");

        // Abort in the fifth round; the queued expectation is withdrawn.
        load_key(KEY_C1);
        send(CT_C1, PT_C1, "rst_abort", acc);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        void'(exp_q.pop_back());
        void'(nm_q.pop_back());
        @(negedge clk);
        chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_out_data", out_data, 128'(0));
        chk("mid_rst_rk_idx", 128'(rk_idx), 128'(10));
        chk("mid_rst_in_ready_held", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        c1_run(1'b0, "post_rst");

        load_key(rand128());
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cts[i] = rand128();
        for (int i = 0; i < 3; i++) send(cts[i], model_dec(cts[i]), $sformatf("b2b_%0d", i), accs[i]);
        in_valid = 1'b0;
        chk("b2b_spacing_01", 128'(accs[1] - accs[0]), 128'(12));
        chk("b2b_spacing_12", 128'(accs[2] - accs[1]), 128'(12));
        drain("b2b");

        for (int i = 0; i < 5; i++) begin
            load_key(rand128());
            ct2 = rand128();
            send(ct2, model_dec(ct2), $sformatf("rand_%0d", i), acc);
            in_valid = 1'b0;
            drain("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
